ptn_gen_multi: RTL

//  Multi-pattern video test generator. Has its own raster timing, selects one of six

---
 rtl/ptn_gen_pkg.sv | 29 ++
 rtl/ptn_timing_gen.sv | 76 +++++++
 rtl/ptn_gen_multi.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ptn_gen_pkg.sv
// rtl/ptn_gen_pkg.sv - pattern mode encodings and colour-bar table for the test generator
package ptn_gen_pkg;

  typedef enum logic [2:0] {
    PTN_HGRAY = 3'd0,
    PTN_VGRAY = 3'd1,
    PTN_CBAR  = 3'd2,
    PTN_CHECK = 3'd3,
    PTN_RAMP  = 3'd4,
    PTN_SOLID = 3'd5,
    PTN_RSVD6 = 3'd6,
    PTN_RSVD7 = 3'd7
  } ptn_mode_e;

  // {R,G,B} on/off per bar, left to right: W,Y,C,G,M,R,B,K
  function automatic logic [2:0] cbar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b111;
      3'd1:    return 3'b110;
      3'd2:    return 3'b011;
      3'd3:    return 3'b010;
      3'd4:    return 3'b101;
      3'd5:    return 3'b100;
      3'd6:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ptn_timing_gen.sv
// rtl/ptn_timing_gen.sv - raster h/v counters, frame counter, sync/DE/frame-start decode
module ptn_timing_gen
  import ptn_gen_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_TOTAL  = 2400,
  parameter int V_ACTIVE = 1080,
  parameter int V_TOTAL  = 1500,
  parameter int H_SYNC_W = 44,
  parameter int V_SYNC_W = 5,
  parameter int CNT_W    = 12,
  parameter int FCNT_W   = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  output logic [CNT_W-1:0]  o_h,
  output logic [CNT_W-1:0]  o_v,
  output logic [FCNT_W-1:0] o_frame_cnt,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_de,
  output logic              o_frame_start
);

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNCE = CNT_W'(H_ACTIVE + H_SYNC_W);
  localparam logic [CNT_W-1:0] V_SYNCE = CNT_W'(V_ACTIVE + V_SYNC_W);

  logic [CNT_W-1:0]  h_q, h_d, v_q, v_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  always_comb begin
    h_d    = h_q + 1'b1;
    v_d    = v_q;
    fcnt_d = fcnt_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d    = '0;
        fcnt_d = fcnt_q + 1'b1;
      end else begin
        v_d = v_q + 1'b1;
      end
    end
    if (!i_en) begin
      h_d    = '0;
      v_d    = '0;
      fcnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_q    <= '0;
      v_q    <= '0;
      fcnt_q <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign o_h           = h_q;
  assign o_v           = v_q;
  assign o_frame_cnt   = fcnt_q;
  assign o_hsync       = (h_q >= H_ACT) && (h_q < H_SYNCE);
  assign o_vsync       = (v_q >= V_ACT) && (v_q < V_SYNCE);
  assign o_de          = (h_q < H_ACT) && (v_q < V_ACT);
  assign o_frame_start = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/ptn_gen_multi.sv
// rtl/ptn_gen_multi.sv - multi-pattern video test generator: mode latch, bar counters, pattern mux, output register
module ptn_gen_multi
  import ptn_gen_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_TOTAL  = 2400,
  parameter int V_ACTIVE = 1080,
  parameter int V_TOTAL  = 1500,
  parameter int H_SYNC_W = 44,
  parameter int V_SYNC_W = 5,
  parameter int CNT_W    = 12,
  parameter int PIX_W    = 8,
  parameter int NUM_BARS = 10,
  parameter int CHK_LOG2 = 6,
  parameter int FCNT_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [2:0]         i_ptn_sel,
  input  logic [3*PIX_W-1:0] i_solid_rgb,
  output logic [PIX_W-1:0]   o_R_data,
  output logic [PIX_W-1:0]   o_G_data,
  output logic [PIX_W-1:0]   o_B_data,
  output logic               o_HSync,
  output logic               o_VSync,
  output logic               o_DE,
  output logic               o_frame_start
);

  localparam int MAX  = (1 << PIX_W) - 1;
  localparam int STEP = MAX / (NUM_BARS - 1);
  localparam logic [CNT_W-1:0] HBAR_W    = CNT_W'(H_ACTIVE / NUM_BARS);
  localparam logic [CNT_W-1:0] VBAR_H    = CNT_W'(V_ACTIVE / NUM_BARS);
  localparam logic [CNT_W-1:0] CBAR_W    = CNT_W'(H_ACTIVE / 8);
  localparam logic [CNT_W-1:0] GRAY_LAST = CNT_W'(NUM_BARS - 1);
  localparam logic [CNT_W-1:0] CBAR_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);

  logic [CNT_W-1:0]  h, v;
  logic [FCNT_W-1:0] frame_cnt;
  logic              hsync, vsync, de, fstart;

  ptn_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL), .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL),
    .H_SYNC_W(H_SYNC_W), .V_SYNC_W(V_SYNC_W), .CNT_W(CNT_W), .FCNT_W(FCNT_W)
  ) u_timing (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
    .o_h(h), .o_v(v), .o_frame_cnt(frame_cnt),
    .o_hsync(hsync), .o_vsync(vsync), .o_de(de), .o_frame_start(fstart)
  );

  // Bar state is {index, position-in-bar}; the index saturates so remainders join the last bar
  function automatic logic [2*CNT_W-1:0] bar_next(input logic [2*CNT_W-1:0] cur,
                                                  input logic [CNT_W-1:0]   width,
                                                  input logic [CNT_W-1:0]   last);
    logic [CNT_W-1:0] k, cnt;
    {k, cnt} = cur;
    if (k == last) return cur;
    if (cnt == width - 1'b1) return {k + 1'b1, {CNT_W{1'b0}}};
    return {k, cnt + 1'b1};
  endfunction

  logic [2*CNT_W-1:0] hbar_q, hbar_d, vbar_q, vbar_d, cbar_q, cbar_d;
  ptn_mode_e          mode_q, mode_d, cur_mode;
  logic [3*PIX_W-1:0] solid_q, solid_d, cur_solid, pix;
  logic [PIX_W-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
  logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic [CNT_W-1:0]   hk, vk, ck;
  logic [2:0]         crgb;
  logic               chk, h_wrap;

  always_comb begin
    h_wrap    = (h == H_LAST);
    cur_mode  = fstart ? ptn_mode_e'(i_ptn_sel) : mode_q;
    cur_solid = fstart ? i_solid_rgb : solid_q;
    mode_d    = cur_mode;
    solid_d   = cur_solid;
    hbar_d    = h_wrap ? '0 : bar_next(hbar_q, HBAR_W, GRAY_LAST);
    cbar_d    = h_wrap ? '0 : bar_next(cbar_q, CBAR_W, CBAR_LAST);
    vbar_d    = vbar_q;
    if (h_wrap) vbar_d = (v == V_LAST) ? '0 : bar_next(vbar_q, VBAR_H, GRAY_LAST);

    hk   = hbar_q[2*CNT_W-1:CNT_W];
    vk   = vbar_q[2*CNT_W-1:CNT_W];
    ck   = cbar_q[2*CNT_W-1:CNT_W];
    crgb = cbar_rgb(ck[2:0]);
    chk  = h[CHK_LOG2] ^ v[CHK_LOG2] ^ frame_cnt[0];
    pix  = '0;
    case (cur_mode)
      PTN_HGRAY: pix = {3{PIX_W'(MAX - STEP * int'(vk))}};
      PTN_VGRAY: pix = {3{PIX_W'(MAX - STEP * int'(hk))}};
      PTN_CBAR:  pix = {{PIX_W{crgb[2]}}, {PIX_W{crgb[1]}}, {PIX_W{crgb[0]}}};
      PTN_CHECK: pix = {3{{PIX_W{chk}}}};
      PTN_RAMP:  pix = {3{PIX_W'(h + CNT_W'(frame_cnt))}};
      PTN_SOLID: pix = cur_solid;
      default:   pix = '0;
    endcase

    {r_d, g_d, b_d} = de ? pix : '0;
    hs_d = hsync;
    vs_d = vsync;
    de_d = de;
    fs_d = fstart;

    // Disabled generator parks at (0,0) with everything dark
    if (!i_en) begin
      hbar_d = '0;
      vbar_d = '0;
      cbar_d = '0;
      mode_d = PTN_HGRAY;
      solid_d = '0;
      {r_d, g_d, b_d} = '0;
      hs_d = 1'b0;
      vs_d = 1'b0;
      de_d = 1'b0;
      fs_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hbar_q  <= '0;
      vbar_q  <= '0;
      cbar_q  <= '0;
      mode_q  <= PTN_HGRAY;
      solid_q <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hbar_q  <= hbar_d;
      vbar_q  <= vbar_d;
      cbar_q  <= cbar_d;
      mode_q  <= mode_d;
      solid_q <= solid_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
    end
  end

  assign o_R_data      = r_q;
  assign o_G_data      = g_q;
  assign o_B_data      = b_q;
  assign o_HSync       = hs_q;
  assign o_VSync       = vs_q;
  assign o_DE          = de_q;
  assign o_frame_start = fs_q;

endmodule
